// File: rtl/bram_rd_streamer_pkg.sv
// Shared definitions for the block-RAM read streamer: RAM defaults,
// address-width helper and the burst state encoding.
package bram_rd_streamer_pkg;

    localparam int RAM_WIDTH_DEF = 32;
    localparam int RAM_DEPTH_DEF = 1024;

    // Number of bits needed to represent the value 'depth'.
    function automatic int clogb2(input int depth);
        int d;
        int bits;
        d    = depth;
        bits = 0;
        for (int i = 0; i < 32; i++) begin
            if (d > 0) begin
                bits = bits + 1;
                d    = d >> 1;
            end
        end
        return bits;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/bram_rd_streamer_return_fifo.sv
// Return buffer for RAM read data: a registered head word feeding the stream
// outputs, backed by a small ring buffer for words arriving while the head is held.
module rd_return_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 3,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_last,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    localparam int BODY  = DEPTH - 1;
    localparam int PTR_W = (BODY > 1) ? $clog2(BODY) : 1;

    logic [WIDTH:0]     body_mem [BODY];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   body_cnt_q, body_cnt_d;
    logic [WIDTH-1:0]   head_data_q, head_data_d;
    logic               head_last_q, head_last_d;
    logic               head_valid_q, head_valid_d;
    logic               body_rd;
    logic               body_we;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BODY - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // The head refills from the ring first so that arrival order is preserved.
    always_comb begin
        head_data_d  = head_data_q;
        head_last_d  = head_last_q;
        head_valid_d = head_valid_q;
        body_rd      = 1'b0;
        body_we      = 1'b0;
        if (!head_valid_q || pop) begin
            if (body_cnt_q != '0) begin
                {head_last_d, head_data_d} = body_mem[rd_ptr_q];
                head_valid_d = 1'b1;
                body_rd      = 1'b1;
                body_we      = push;
            end else begin
                head_valid_d = push;
                head_last_d  = push & push_last;
                if (push) begin
                    head_data_d = push_data;
                end
            end
        end else begin
            body_we = push;
        end
    end

    always_comb begin
        rd_ptr_d   = body_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d   = body_we ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        body_cnt_d = body_cnt_q + CNT_W'(body_we) - CNT_W'(body_rd);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            body_cnt_q   <= '0;
            head_data_q  <= '0;
            head_last_q  <= 1'b0;
            head_valid_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            body_cnt_q   <= body_cnt_d;
            head_data_q  <= head_data_d;
            head_last_q  <= head_last_d;
            head_valid_q <= head_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (body_we) begin
            body_mem[wr_ptr_q] <= {push_last, push_data};
        end
    end

    // The issue-side credit check must make overflow impossible.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!push || pop || (count < CNT_W'(DEPTH)));
        end
    end

    assign head_data  = head_data_q;
    assign head_last  = head_last_q;
    assign head_valid = head_valid_q;
    assign count      = CNT_W'(head_valid_q) + body_cnt_q;

endmodule

// File: rtl/bram_rd_streamer.sv
// Burst read master for a simple-dual-port block RAM: issues sequential reads
// and returns the words as a valid/ready stream with last-beat marking.
module bram_rd_streamer
    import bram_rd_streamer_pkg::*;
#(
    parameter  int RAM_WIDTH    = RAM_WIDTH_DEF,
    parameter  int RAM_DEPTH    = RAM_DEPTH_DEF,
    parameter  int READ_LATENCY = 1,
    parameter  int FIFO_DEPTH   = READ_LATENCY + 2,
    localparam int ADDR_W       = clogb2(RAM_DEPTH - 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [ADDR_W:0]      cmd_len,
    output logic [ADDR_W-1:0]    addr_r,
    output logic                 en_r,
    output logic                 reg_ce_r,
    output logic                 rst_r,
    input  logic [RAM_WIDTH-1:0] dout_r,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IF_W  = $clog2(READ_LATENCY + 1);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [LEN_W-1:0]        rem_q, rem_d;
    logic                    done_q, done_d;
    logic [IF_W-1:0]         inflight_q, inflight_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [READ_LATENCY-1:0] last_q, last_d;

    logic                    issue;
    logic                    credit_ok;
    logic                    pop;
    logic                    push;
    logic                    push_last;
    logic [CNT_W-1:0]        fifo_count;
    logic [RAM_WIDTH-1:0]    head_data;
    logic                    head_last;
    logic                    head_valid;

    assign pop = head_valid & m_ready;

    // Buffered words plus reads still in the RAM pipe may never exceed the buffer.
    always_comb begin
        credit_ok = (int'(fifo_count) + int'(inflight_q)) < (FIFO_DEPTH + int'(pop));
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len != '0) begin
                        addr_d  = cmd_addr;
                        rem_d   = cmd_len;
                        state_d = ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if ((rem_q != '0) && credit_ok) begin
                    issue  = 1'b1;
                    addr_d = (addr_q == ADDR_W'(RAM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((inflight_q == '0) && pop && head_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read-valid pipe matching the RAM latency; the tail stage is the push strobe.
    assign vld_d[0]  = issue;
    assign last_d[0] = issue & (rem_q == LEN_W'(1));

    for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
        assign vld_d[gi]  = vld_q[gi-1];
        assign last_d[gi] = last_q[gi-1];
    end

    assign push      = vld_q[READ_LATENCY-1];
    assign push_last = last_q[READ_LATENCY-1];

    always_comb begin
        inflight_d = inflight_q + IF_W'(issue) - IF_W'(push);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            inflight_q <= '0;
            vld_q      <= '0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            inflight_q <= inflight_d;
            vld_q      <= vld_d;
            last_q     <= last_d;
        end
    end

    rd_return_fifo #(
        .WIDTH (RAM_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (dout_r),
        .push_last  (push_last),
        .pop        (pop),
        .head_data  (head_data),
        .head_last  (head_last),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign en_r      = issue;
    assign addr_r    = addr_q;
    assign reg_ce_r  = 1'b1;
    assign rst_r     = ~rst_n;
    assign done      = done_q;
    assign m_data    = head_data;
    assign m_valid   = head_valid;
    assign m_last    = head_last;

endmodule

// File: doc/bram_rd_streamer.md
Name: bram_rd_streamer

Overview:
- Read-side master for the simple-dual-port block RAM.
- Accepts a burst command (start address, beat count) and issues sequential reads on the RAM read port.
- Absorbs the RAM's fixed read latency and delivers the words as a valid/ready stream with last-beat marking.
- Sustains one beat per cycle under no backpressure and never drops a word under backpressure.

Parameters:
- RAM_WIDTH, 32, data word width; must match the RAM instance.
- RAM_DEPTH, 1024, RAM word count; ADDR_W = clogb2(RAM_DEPTH-1).
- READ_LATENCY, 1, RAM read latency in cycles: 1 = low-latency RAM, 2 = output-registered RAM. No other value is legal.
- FIFO_DEPTH, READ_LATENCY+2, capacity of the internal return buffer.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  streamer idle and able to accept a command.
- cmd_addr  in  ADDR_W  first word address.
- cmd_len  in  ADDR_W+1  beat count, 0..RAM_DEPTH.
- addr_r  out  ADDR_W  RAM read address.
- en_r  out  1  RAM read enable; high only on cycles that issue a read.
- reg_ce_r  out  1  RAM output-register enable; constant 1.
- rst_r  out  1  RAM output-register reset; equals !rst_n.
- dout_r  in  RAM_WIDTH  RAM read data.
- m_data  out  RAM_WIDTH  stream data.
- m_valid  out  1  stream beat valid.
- m_ready  in  1  consumer accepts the beat.
- m_last  out  1  final beat of the burst.
- busy  out  1  a burst is in progress.
- done  out  1  one-cycle pulse on burst completion.

Behaviour:
- Reset values: cmd_ready=1, en_r=0, addr_r=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0.
- Reset clears the state machine, counters, in-flight valid pipe and buffer. Reset mid-burst discards all data; no done pulse is produced.
- States:
  - IDLE: cmd_ready=1. On cmd_valid with cmd_len!=0, latch addr and remaining=cmd_len, go to ISSUE. On cmd_valid with cmd_len==0, stay in IDLE and pulse done the next cycle; no beats are produced.
  - ISSUE: a read issues in any cycle where remaining>0 and occ + inflight - pop < FIFO_DEPTH. pop = m_valid & m_ready this cycle; inflight = reads issued but not yet returned.
  - On issue: en_r=1, addr_r=current addr. Then addr increments, wrapping RAM_DEPTH-1 -> 0, and remaining decrements.
  - ISSUE goes to DRAIN when the last read issues.
  - DRAIN: wait until inflight==0 and the last beat has been handshaken, then go to IDLE with done=1 for the following cycle.
- busy = (state != IDLE).
- Return path:
  - A READ_LATENCY-deep shift register tracks issued reads, with one extra flag marking the final read.
  - dout_r is valid in the cycle READ_LATENCY after the en_r cycle and is pushed into the buffer at that edge.
  - The buffer is a first-word-registered FIFO. m_data, m_valid and m_last come from its head.
- Latency:
  - Command accepted at edge 0. First en_r is in cycle 1. First m_valid is in cycle 2+READ_LATENCY.
  - With m_ready held at 1, beats are back-to-back.
- Backpressure:
  - m_valid/m_data/m_last are held stable while m_valid & !m_ready.
  - Issue stalls once the credit bound is reached. The buffer never overflows; assert this in simulation.
- Simultaneous push and pop: occupancy is unchanged and order is preserved.
- m_last is high only on the beat carrying the final address of the burst.
- cmd_ready=0 outside IDLE. Commands offered while busy are ignored until IDLE.

Decomposition:
- Shared package/header (existing CPU parameter include): RAM_WIDTH, RAM_DEPTH defaults, the clogb2 function, and the state encodings (IDLE, ISSUE, DRAIN).
- One sub-module: rd_return_fifo, a synchronous FIFO parameterised on width and depth.
  - Ports: push, push_data, push_last, pop, head_data, head_last, head_valid, count.
  - Synchronous active-low reset.

Test Plan:
- Low-latency RAM preloaded with mem[i]=i+0x100, cmd addr=4, len=8, m_ready=1 -> m_valid first in cycle 3; 8 consecutive beats 0x104..0x10B; m_last on 0x10B; done one cycle later; cmd_ready returns to 1.
- Wrap: RAM_DEPTH=1024, addr=1022, len=4 -> addr_r sequence 1022, 1023, 0, 1; data matches mem.
- Backpressure: m_ready toggled 1,0,0,1 repeating, len=16, both READ_LATENCY=1 and 2 -> all 16 words delivered in order with no loss or duplication; buffer count never exceeds FIFO_DEPTH; m_data stable during stalls.
- cmd_len=0 -> no en_r, no m_valid, done pulses exactly once the next cycle.
- Reset mid-burst: assert rst_n=0 after 3 beats of a len=10 burst -> next cycle m_valid=0, busy=0, cmd_ready=1, no done. A following burst (addr=0, len=2) returns mem[0], mem[1] only.
- READ_LATENCY=2, len=1 -> single beat with m_last=1; first m_valid in cycle 4 after acceptance; rst_r mirrors !rst_n.
